uart_loader: RTL and testbench

- Program-loader controller that sits downstream of the 8N1 UART receiver.
- Consumes the receiver's byte strobe and data, parses framed load packets, and writes payload bytes into CPU instruction/data memory.
- Holds the CPU in reset while loading and releases it on a RUN command.
- Gives the host a checksum-verified, timeout-guarded path for downloading programs to the 8-bit CPU.

---
 rtl/uart_loader.sv | 147 ++++++++++++++
 tb/tb_uart_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: turns the UART receiver's byte stream into memory writes.
// Packets are SYNC, ADDR, LEN, LEN data bytes, CHK, where LEN=0 means 256 bytes.
// The CPU is held in reset from the first SYNC byte until a RUN byte arrives in IDLE.
// A stall between bytes inside a packet aborts the packet and raises the sticky error flag.
module uart_loader #(
  parameter int         ADDR_W        = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter logic [7:0] RUN_BYTE      = 8'h5A,
  parameter int         TIMEOUT_CLKS  = 100000,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  // TW is sized to hold TIMEOUT_CLKS, so the counter cannot wrap before it expires.
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t            state_reg;
  logic [TW-1:0]     timer_reg;
  logic [ADDR_W-1:0] start_reg;
  logic [8:0]        count_reg;     // bytes in this packet, 1..256
  logic [8:0]        idx_reg;       // index of the next data byte
  logic [7:0]        checksum_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_wdata_reg;
  logic              cpu_hold_reg;
  logic              busy_reg;
  logic              load_done_reg;
  logic              load_error_reg;
  logic              timeout_hit;

  // The inter-byte gap has used up its allowance.
  assign timeout_hit = (timer_reg == TW'(TIMEOUT_CLKS - 1));

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign cpu_hold   = cpu_hold_reg;
  assign busy       = busy_reg;
  assign load_done  = load_done_reg;
  assign load_error = load_error_reg;

  // Packet parser, timeout guard and registered memory-write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      start_reg      <= '0;
      count_reg      <= '0;
      idx_reg        <= '0;
      checksum_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_hold_reg   <= HOLD_AT_RESET;
      busy_reg       <= 1'b0;
      load_done_reg  <= 1'b0;
      load_error_reg <= 1'b0;
    end else begin
      // Write strobe and done flag are single-cycle pulses.
      mem_we_reg    <= 1'b0;
      load_done_reg <= 1'b0;

      // The counter only runs inside a packet and restarts on every byte.
      if (state_reg == S_IDLE || rx_valid) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end

      if (state_reg != S_IDLE && !rx_valid && timeout_hit) begin
        // An arriving byte takes priority over expiry, hence the !rx_valid term.
        state_reg      <= S_IDLE;
        busy_reg       <= 1'b0;
        load_error_reg <= 1'b1;
      end else if (rx_valid) begin
        case (state_reg)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_reg    <= S_ADDR;
              busy_reg     <= 1'b1;
              cpu_hold_reg <= 1'b1;
            end else if (rx_data == RUN_BYTE) begin
              cpu_hold_reg <= 1'b0;
            end
          end
          S_ADDR: begin
            start_reg    <= ADDR_W'(rx_data);
            checksum_reg <= rx_data;
            state_reg    <= S_LEN;
          end
          S_LEN: begin
            count_reg    <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            checksum_reg <= checksum_reg + rx_data;
            idx_reg      <= '0;
            state_reg    <= S_DATA;
          end
          S_DATA: begin
            // Marker values are ordinary payload here.
            checksum_reg  <= checksum_reg + rx_data;
            mem_we_reg    <= 1'b1;
            mem_wdata_reg <= rx_data;
            mem_addr_reg  <= start_reg + ADDR_W'(idx_reg);
            idx_reg       <= idx_reg + 9'd1;
            if (idx_reg == count_reg - 9'd1) begin
              state_reg <= S_CHK;
            end
          end
          S_CHK: begin
            if (checksum_reg == rx_data) begin
              load_done_reg  <= 1'b1;
              load_error_reg <= 1'b0;
            end else begin
              load_error_reg <= 1'b1;
            end
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized packets against a packet-level reference model.
// The model computes expected writes and checksum verdicts from whole packets;
// a negedge monitor records every memory write into a shadow image.
module tb_uart_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_error;

  uart_loader #(
    .ADDR_W(8),
    .SYNC_BYTE(8'hA5),
    .RUN_BYTE(8'h5A),
    .TIMEOUT_CLKS(50),
    .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err = 0;
  int         we_count = 0;
  int         done_count = 0;
  logic [7:0] obs_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] pkt_data [$];

  // Shadow memory and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      obs_mem[mem_addr] = mem_wdata;
      we_count++;
    end
    if (load_done) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One rx_valid pulse; returns at posedge+1 of the consuming edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends SYNC, ADDR, LEN, pkt_data, CHK. auto_chk replaces chk with the correct sum.
  // abort_after > 0 stops right after that many data bytes.
  task automatic send_packet(input string tag, input logic [7:0] addr, input logic [7:0] len,
                             input logic [7:0] chk, input bit auto_chk, input int gap_max,
                             input int abort_after);
    int         n;
    int         sum;
    int         we_before;
    int         done_before;
    logic [7:0] chkb;
    bit         good;
    n           = (len == 8'd0) ? 256 : int'(len);
    sum         = int'(addr) + int'(len);
    we_before   = we_count;
    done_before = done_count;
    send_byte(8'hA5);
    check({tag, "_sync_busy"}, busy, 1);
    check({tag, "_sync_hold"}, cpu_hold, 1);
    idle($urandom_range(0, gap_max));
    send_byte(addr);
    idle($urandom_range(0, gap_max));
    send_byte(len);
    idle($urandom_range(0, gap_max));
    for (int i = 0; i < n; i++) begin
      send_byte(pkt_data[i]);
      sum = sum + int'(pkt_data[i]);
      exp_mem[(int'(addr) + i) % 256] = pkt_data[i];
      if (i < 3 || i == n - 1) begin
        check({tag, "_we"}, mem_we, 1);
        check({tag, "_addr"}, mem_addr, (int'(addr) + i) % 256);
        check({tag, "_wdata"}, mem_wdata, pkt_data[i]);
      end
      if (abort_after == i + 1) return;
      idle($urandom_range(0, gap_max));
    end
    chkb = auto_chk ? 8'(sum % 256) : chk;
    good = (int'(chkb) == sum % 256);
    send_byte(chkb);
    check({tag, "_done"}, load_done, good);
    check({tag, "_error"}, load_error, !good);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_hold_end"}, cpu_hold, 1);
    check({tag, "_we_count"}, we_count - we_before, n);
    idle(1);
    check({tag, "_done_count"}, done_count - done_before, good ? 1 : 0);
    $display("packet %s addr=%02h len=%0d chk=%02h good=%0d", tag, addr, n, chkb, good);
  endtask

  task automatic load_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pkt_data.delete();
    pkt_data.push_back(a);
    pkt_data.push_back(b);
    pkt_data.push_back(c);
  endtask

  initial begin
    int         snap;
    int         mism;
    logic [7:0] ra;
    logic [7:0] rl;
    logic [7:0] rc;
    bit         rgood;
    for (int i = 0; i < 256; i++) begin
      obs_mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end

    // Reset state
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    $display("reset checked");

    // Basic load: A5 10 03 11 22 33 79
    load_bytes(8'h11, 8'h22, 8'h33);
    send_packet("basic", 8'h10, 8'h03, 8'h79, 1'b0, 0, 0);

    // Run command releases the CPU without writing
    snap = we_count;
    send_byte(8'h5A);
    check("run_hold", cpu_hold, 0);
    check("run_busy", busy, 0);
    idle(2);
    check("run_no_we", we_count - snap, 0);
    $display("run command sent");
    send_byte(8'hA5);
    check("resync_hold", cpu_hold, 1);
    check("resync_busy", busy, 1);
    // Leave the half-open packet to time out
    idle(60);
    check("resync_to_busy", busy, 0);
    check("resync_to_error", load_error, 1);
    $display("sync after run timed out");

    // Bad checksum then recovery
    load_bytes(8'h11, 8'h22, 8'h33);
    send_packet("badchk", 8'h10, 8'h03, 8'h78, 1'b0, 1, 0);
    pkt_data.delete();
    pkt_data.push_back(8'hAA);
    send_packet("recover", 8'h00, 8'h01, 8'hAB, 1'b0, 1, 0);

    // Address wrap with embedded marker bytes
    load_bytes(8'hA5, 8'h5A, 8'h01);
    send_packet("wrap", 8'hFE, 8'h03, 8'h01, 1'b0, 2, 0);

    // Explicit timeout window
    snap = done_count;
    send_byte(8'hA5);
    send_byte(8'h20);
    idle(45);
    check("to_busy_early", busy, 1);
    idle(10);
    check("to_busy_late", busy, 0);
    check("to_error", load_error, 1);
    check("to_hold", cpu_hold, 1);
    check("to_no_done", done_count - snap, 0);
    $display("timeout observed");
    pkt_data.delete();
    pkt_data.push_back(8'h55);
    send_packet("after_to", 8'h20, 8'h01, 8'h76, 1'b0, 0, 0);

    // Randomized packets, some with corrupted checksums
    for (int p = 0; p < 6; p++) begin
      ra = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(1, 20));
      pkt_data.delete();
      for (int i = 0; i < int'(rl); i++) pkt_data.push_back(8'($urandom_range(0, 255)));
      rgood = ($urandom_range(0, 2) != 0);
      if (rgood) begin
        send_packet("rand_good", ra, rl, 8'h00, 1'b1, 3, 0);
      end else begin
        // Correct sum plus a nonzero offset is guaranteed wrong
        rc = ra + rl;
        for (int i = 0; i < int'(rl); i++) rc = rc + pkt_data[i];
        rc = rc + 8'($urandom_range(1, 255));
        send_packet("rand_bad", ra, rl, rc, 1'b0, 3, 0);
      end
    end

    // LEN=0 means 256 bytes
    pkt_data.delete();
    for (int i = 0; i < 256; i++) pkt_data.push_back(8'h01);
    send_packet("len0", 8'h00, 8'h00, 8'h00, 1'b0, 0, 0);

    // Same packet, reset after 100 data bytes
    for (int i = 0; i < 256; i++) pkt_data[i] = 8'($urandom_range(0, 255));
    send_packet("abort", 8'h40, 8'h00, 8'h00, 1'b1, 0, 100);
    rst = 1'b1;
    rx_data = 8'hA5;
    rx_valid = 1'b1;   // ignored while in reset
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idle(1);
    rst = 1'b0;
    check("abort_we", mem_we, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_busy", busy, 0);
    check("abort_hold", cpu_hold, 1);
    check("abort_error", load_error, 0);
    snap = we_count;
    for (int i = 0; i < 5; i++) send_byte(pkt_data[100 + i] == 8'hA5 ? 8'h01 : pkt_data[100 + i]);
    idle(2);
    check("abort_no_we", we_count - snap, 0);
    check("abort_idle_busy", busy, 0);
    $display("reset mid-packet checked");
    load_bytes(8'hC3, 8'h3C, 8'h99);
    send_packet("post_abort", 8'h80, 8'h03, 8'h00, 1'b1, 1, 0);

    // Whole memory image against the model
    mism = 0;
    for (int i = 0; i < 256; i++) if (obs_mem[i] !== exp_mem[i]) mism++;
    check("mem_image", mism, 0);
    $display("memory image compared, mismatching locations=%0d", mism);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
